// File: rtl/ch_sar_search.sv
// rtl/ch_sar_search.sv - successive-approximation DAC threshold search for one comparator channel
// Optional strobe timeout with sticky err_o port: define SAR_STB_TIMEOUT_EN.
module ch_sar_search #(
  parameter int CODE_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int VOTES         = 3
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  run_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CODE_WIDTH-1:0] result_o,
  output logic [CODE_WIDTH-1:0] dac_code_o,
  output logic                  dac_wre_o,
  input  logic                  dac_rdy_i,
  output logic                  stb_req_o,
`ifdef SAR_STB_TIMEOUT_EN
  output logic                  err_o,
`endif
  input  logic                  stb_valid_i,
  input  logic                  cmp_i
);
  localparam int BW = $clog2(CODE_WIDTH);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CODE_WIDTH-1:0] ONE     = CODE_WIDTH'(1);
  localparam logic [3:0]            VOTES_N = 4'(VOTES);
  localparam logic [3:0]            MAJ     = 4'(VOTES / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SET_DAC, S_WAIT_DAC, S_SETTLE, S_STROBE, S_DECIDE, S_DONE
  } state_t;

  state_t                state;
  logic [CODE_WIDTH-1:0] acc;
  logic [CODE_WIDTH-1:0] acc_next;
  logic [BW-1:0]         bit_idx;
  logic [SW-1:0]         settle_cnt;
  logic [3:0]            ones;
  logic [3:0]            n;
  logic                  wait_first;
  logic                  to_hit;
  logic                  abort;

`ifdef SAR_STB_TIMEOUT_EN
  logic [31:0]           to_cnt;
  assign to_hit = (state == S_STROBE) && !stb_valid_i && (to_cnt == 32'hFFFF_FFFF);
`else
  assign to_hit = 1'b0;
`endif

  // Abort wins over every state action, so a strobe coinciding with run_i falling is dropped.
  assign abort    = (state != S_IDLE) && (!run_i || to_hit);
  assign acc_next = (ones > MAJ) ? (acc | (ONE << bit_idx)) : acc;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= S_IDLE;
      acc        <= '0;
      bit_idx    <= '0;
      settle_cnt <= '0;
      ones       <= '0;
      n          <= '0;
      wait_first <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      dac_code_o <= '0;
      dac_wre_o  <= 1'b0;
      stb_req_o  <= 1'b0;
`ifdef SAR_STB_TIMEOUT_EN
      to_cnt     <= '0;
      err_o      <= 1'b0;
`endif
    end else begin
      dac_wre_o <= 1'b0;
      done_o    <= 1'b0;
`ifdef SAR_STB_TIMEOUT_EN
      if (to_hit) err_o <= 1'b1;
`endif
      if (abort) begin
        state     <= S_IDLE;
        busy_o    <= 1'b0;
        stb_req_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && run_i) begin
              acc     <= '0;
              bit_idx <= BW'(CODE_WIDTH - 1);
              busy_o  <= 1'b1;
              state   <= S_SET_DAC;
`ifdef SAR_STB_TIMEOUT_EN
              err_o   <= 1'b0;
`endif
            end
          end
          S_SET_DAC: begin
            if (dac_rdy_i) begin
              dac_code_o <= acc | (ONE << bit_idx);
              dac_wre_o  <= 1'b1;
              wait_first <= 1'b1;
              state      <= S_WAIT_DAC;
            end
          end
          // The SPI master may still show rdy in the cycle right after wre.
          S_WAIT_DAC: begin
            if (wait_first) begin
              wait_first <= 1'b0;
            end else if (dac_rdy_i) begin
              settle_cnt <= SW'(SETTLE_CYCLES);
              state      <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle_cnt == '0) begin
              ones      <= '0;
              n         <= '0;
              stb_req_o <= 1'b1;
              state     <= S_STROBE;
`ifdef SAR_STB_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
          S_STROBE: begin
            if (n == VOTES_N) begin
              stb_req_o <= 1'b0;
              state     <= S_DECIDE;
            end else if (stb_valid_i) begin
              n    <= n + 4'd1;
              ones <= ones + {3'b000, cmp_i};
            end
`ifdef SAR_STB_TIMEOUT_EN
            if (stb_valid_i) to_cnt <= '0;
            else             to_cnt <= to_cnt + 32'd1;
`endif
          end
          // Result is published here so done_o shows while busy_o is still high.
          S_DECIDE: begin
            acc <= acc_next;
            if (bit_idx == '0) begin
              result_o <= acc_next;
              done_o   <= 1'b1;
              state    <= S_DONE;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              state   <= S_SET_DAC;
            end
          end
          S_DONE: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ch_sar_search.sv
// tb/tb_ch_sar_search.sv - self-checking bench for ch_sar_search
// Define SAR_STB_TIMEOUT_EN to also exercise the strobe timeout.
`timescale 1ns/1ps
module tb_ch_sar_search;
  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        run_i = 1'b0;
  logic        start_i = 1'b0;
  logic        dac_rdy_i = 1'b1;
  logic        stb_valid_i = 1'b0;
  logic        cmp_i = 1'b0;
  logic        busy_o, done_o, dac_wre_o, stb_req_o;
  logic [15:0] result_o, dac_code_o;
`ifdef SAR_STB_TIMEOUT_EN
  logic        err_o;
`endif

  int          checks = 0;
  int          failures = 0;
  int          mode = 2;
  logic [15:0] thr = 16'h0;
  logic [2:0]  pat = 3'b000;
  bit          rdy_block = 1'b0;
  bit          stb_en = 1'b1;
  int          spi_busy = 0, stb_cnt = 0, gap_cnt = 0, last_gap = 0;
  int          wre_cnt = 0, strobes = 0, done_cnt = 0, bad_req = 0;
  logic [15:0] first_code = 16'h0;
  logic        prev_req = 1'b0;

  ch_sar_search #(.CODE_WIDTH(16), .SETTLE_CYCLES(8), .VOTES(3)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .run_i(run_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .dac_code_o(dac_code_o), .dac_wre_o(dac_wre_o), .dac_rdy_i(dac_rdy_i),
    .stb_req_o(stb_req_o),
`ifdef SAR_STB_TIMEOUT_EN
    .err_o(err_o),
`endif
    .stb_valid_i(stb_valid_i), .cmp_i(cmp_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic model_cmp(input int m, input logic [15:0] code, input logic [15:0] th,
                                     input logic [2:0] p, input int vidx, input int wc);
    case (m)
      1: return 1'b1;
      2: return 1'b0;
      3: if (wc == 1 && vidx < 3) return p[vidx]; else return code <= th;
      default: return code <= th;
    endcase
  endfunction

  // DAC SPI master, strobe generator and comparator models, all acting on the falling edge.
  initial forever begin
    @(negedge clk_i);
    if (dac_wre_o) begin
      wre_cnt++;
      if (wre_cnt == 1) first_code = dac_code_o;
      if (stb_req_o) bad_req++;
      spi_busy = 6;
      gap_cnt = 0;
    end else begin
      gap_cnt++;
      if (spi_busy > 0) begin
        spi_busy--;
        if (stb_req_o) bad_req++;
      end
    end
    dac_rdy_i = !rdy_block && (spi_busy == 0);
    if (stb_req_o && !prev_req) last_gap = gap_cnt;
    prev_req = stb_req_o;
    if (done_o) done_cnt++;
    cmp_i = model_cmp(mode, dac_code_o, thr, pat, strobes, wre_cnt);
    if (stb_req_o && stb_en) begin
      if (stb_cnt == 19) begin
        stb_valid_i = 1'b1;
        stb_cnt = 0;
        strobes++;
      end else begin
        stb_valid_i = 1'b0;
        stb_cnt++;
      end
    end else begin
      stb_valid_i = 1'b0;
      stb_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
  endtask

  task automatic clear_counts();
    wre_cnt = 0; strobes = 0; first_code = 16'h0;
  endtask

  typedef struct {
    int          mode;
    logic [2:0]  pat;
    logic [15:0] thr;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs[8];
  bit   seen;
  int   d0, early;

  initial begin
    vecs[0] = '{0, 3'b000, 16'h5A3C, 16'h5A3C};
    vecs[1] = '{1, 3'b000, 16'h0000, 16'hFFFF};
    vecs[2] = '{2, 3'b000, 16'h0000, 16'h0000};
    vecs[3] = '{3, 3'b101, 16'h1234, 16'h8000};
    vecs[4] = '{3, 3'b010, 16'h1234, 16'h1234};
    vecs[5] = '{0, 3'b000, 16'h0000, 16'h0000};
    vecs[6] = '{0, 3'b000, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{0, 3'b000, 16'h8000, 16'h8000};

    run_i = 1'b1;
    repeat (3) @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_code", dac_code_o, 0);
    chk("rst_wre", dac_wre_o, 0);
    chk("rst_req", stb_req_o, 0);

    // start -> first wre latency with rdy already high
    mode = 2; clear_counts();
    pulse_start();
    chk("lat_busy", busy_o, 1);
    chk("lat_wre_early", dac_wre_o, 0);
    @(negedge clk_i);
    chk("lat_wre", dac_wre_o, 1);
    chk("lat_code", dac_code_o, 16'h8000);
    wait_done(5000, seen);
    chk("lat_done_seen", seen, 1);
    chk("lat_result", result_o, 16'h0000);
    repeat (3) @(negedge clk_i);

    for (int v = 0; v < 8; v++) begin
      mode = vecs[v].mode; thr = vecs[v].thr; pat = vecs[v].pat;
      clear_counts();
      d0 = done_cnt;
      pulse_start();
      wait_done(5000, seen);
      chk($sformatf("v%0d_done_seen", v), seen, 1);
      chk($sformatf("v%0d_result", v), result_o, vecs[v].exp_res);
      chk($sformatf("v%0d_busy_at_done", v), busy_o, 1);
      repeat (5) @(negedge clk_i);
      chk($sformatf("v%0d_done_cnt", v), done_cnt - d0, 1);
      chk($sformatf("v%0d_busy_end", v), busy_o, 0);
      chk($sformatf("v%0d_wre_cnt", v), wre_cnt, 16);
      chk($sformatf("v%0d_strobes", v), strobes, 48);
      chk($sformatf("v%0d_first_code", v), first_code, 16'h8000);
      chk($sformatf("v%0d_settle_gap", v), last_gap, 16);
    end

    // DAC not ready for 100 cycles in SET_DAC
    rdy_block = 1'b1; mode = 1;
    repeat (2) @(negedge clk_i);
    clear_counts();
    pulse_start();
    early = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (dac_wre_o) early++;
    end
    chk("rdy_no_wre", early, 0);
    chk("rdy_busy", busy_o, 1);
    rdy_block = 1'b0;
    for (int i = 0; i < 5 && wre_cnt == 0; i++) @(negedge clk_i);
    chk("rdy_wre_after", wre_cnt, 1);
    wait_done(5000, seen);
    chk("rdy_done_seen", seen, 1);
    chk("rdy_result", result_o, 16'hFFFF);
    chk("req_low_wait_settle", bad_req, 0);
    repeat (3) @(negedge clk_i);

    // abort mid-STROBE at bit 9
    mode = 0; thr = 16'h5A3C; clear_counts();
    pulse_start();
    for (int i = 0; i < 5000 && !(wre_cnt == 7 && stb_req_o); i++) @(negedge clk_i);
    chk("abort_reached", wre_cnt == 7 && stb_req_o, 1);
    chk("abort_trial_code", dac_code_o, 16'h5A00);
    repeat (25) @(negedge clk_i);
    d0 = done_cnt;
    run_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", busy_o, 0);
    chk("abort_req", stb_req_o, 0);
    repeat (40) @(negedge clk_i);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_result_kept", result_o, 16'hFFFF);
    run_i = 1'b1; clear_counts();
    pulse_start();
    chk("restart_busy", busy_o, 1);
    @(negedge clk_i);
    chk("restart_wre", dac_wre_o, 1);
    chk("restart_code", dac_code_o, 16'h8000);
    wait_done(5000, seen);
    chk("restart_done_seen", seen, 1);
    chk("restart_result", result_o, 16'h5A3C);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("start_at_done_ignored", busy_o, 0);
    chk("start_at_done_no_wre", wre_cnt, 16);

`ifdef SAR_STB_TIMEOUT_EN
    stb_en = 1'b0; mode = 2; clear_counts();
    pulse_start();
    for (int i = 0; i < 200 && !stb_req_o; i++) @(negedge clk_i);
    chk("to_req", stb_req_o, 1);
    force dut.to_cnt = 32'hFFFF_FFF0;
    @(negedge clk_i);
    release dut.to_cnt;
    repeat (30) @(negedge clk_i);
    chk("to_err", err_o, 1);
    chk("to_busy", busy_o, 0);
    chk("to_req_low", stb_req_o, 0);
    stb_en = 1'b1; clear_counts();
    pulse_start();
    chk("to_err_cleared", err_o, 0);
    wait_done(5000, seen);
    chk("to_rerun_done", seen, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
